nibble_serial_addsub: RTL and testbench



---
 rtl/nibble_serial_addsub_pkg.sv | 22 ++
 rtl/nibble_serial_addsub_slice.sv | 21 ++
 rtl/nibble_serial_addsub.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_addsub.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/sub unit.
// The 4-bit slice is time-multiplexed across the operand width.
package nibble_serial_addsub_pkg;

  localparam int NIB = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(int width);
    int n;
    n = width / NIB;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_slice.sv
// 4-bit add slice with carry in/out.
// Purely combinational.
module nibble_serial_addsub_slice
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIB-1:0] a_in,
  input  logic [NIB-1:0] b_in,
  input  logic           cin_in,
  output logic [NIB-1:0] sum_out,
  output logic           cout_out
);

  logic [NIB:0] full;

  always_comb begin
    full = {1'b0, a_in} + {1'b0, b_in} + {{NIB{1'b0}}, cin_in};
    sum_out  = full[NIB-1:0];
    cout_out = full[NIB];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/sub, one nibble per cycle, LSB first.
// Carry chains through a flop; flags load only on completion.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             control_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int N  = WIDTH / NIB;
  localparam int CW = cnt_width(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic           accept;
  logic           last;
  logic [NIB-1:0] b_nib;
  logic [NIB-1:0] s_sum;
  logic           s_cout;

  assign accept = (state_q != RUN) && start_in;
  assign last   = (state_q == RUN) && (cnt_q == CW'(N - 1));

  // B is stored raw; subtract inverts it as each nibble is consumed
  assign b_nib = b_q[NIB-1:0] ^ {NIB{op_q == OP_SUB}};

  nibble_serial_addsub_slice u_slice (
    .a_in     (a_q[NIB-1:0]),
    .b_in     (b_nib),
    .cin_in   (cin_q),
    .sum_out  (s_sum),
    .cout_out (s_cout)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state_q == RUN);
    done_out = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    op_d    = op_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d    = a_in;
      b_d    = b_in;
      op_d   = control_in;
      cin_d  = control_in;
      cnt_d  = '0;
      work_d = '0;
    end else if (state_q == RUN) begin
      // Operands shift down; results shift in from the top
      a_d    = a_q >> NIB;
      b_d    = b_q >> NIB;
      work_d = {s_sum, work_q[WIDTH-1:NIB]};
      cin_d  = s_cout;
      cnt_d  = cnt_q + CW'(1);
      if (last) begin
        sum_d   = work_d;
        carry_d = s_cout;
        ovf_d   = (a_q[NIB-1] == b_nib[NIB-1]) &&
                  (s_sum[NIB-1] != a_q[NIB-1]);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_out      = sum_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub at WIDTH=16.
// Directed vectors; a negedge monitor checks every done pulse.
module tb_nibble_serial_addsub;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ctl;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry;
  logic        ovf;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   dones  = 0;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_in     (start),
    .a_in         (a),
    .b_in         (b),
    .control_in   (ctl),
    .busy_out     (busy),
    .done_out     (done),
    .sum_out      (sum),
    .carry_out    (carry),
    .overflow_out (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      dones++;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("carry", 32'(carry), 32'(e.c));
        chk("overflow", 32'(ovf), 32'(e.v));
      end
    end
  end

  task automatic issue(logic [15:0] ia, logic [15:0] ib, logic ic,
                       logic [15:0] es, logic ec, logic ev);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    ctl   = ic;
    e.s = es;
    e.c = ec;
    e.v = ev;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    ctl   = 1'($urandom);
  endtask

  task automatic wait_done(string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
  endtask

  task automatic idle_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    int bc;
    int d0;
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    ctl   = 1'b0;
    idle_cycles(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    idle_cycles(1);

    // Latency and busy width on a plain add
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    k  = 1;
    bc = 0;
    while (done !== 1'b1 && k < 30) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      k++;
    end
    chk("done_latency", 32'(k), 5);
    chk("busy_cycles", 32'(bc), 4);
    chk("busy_in_done", 32'(busy), 0);

    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_done("wrap");
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    wait_done("ovf_add");
    issue(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    wait_done("sub_borrow");
    issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    wait_done("ovf_sub");

    // Start re-pulsed mid-RUN must be ignored
    issue(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    d0 = dones;
    @(negedge clk);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    ctl   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid_start");
    idle_cycles(8);
    chk("mid_start_dones", 32'(dones - d0), 1);

    // Back-to-back: start held during DONE
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    wait_done("b2b_first");
    start = 1'b1;
    a     = 16'h0010;
    b     = 16'h0001;
    ctl   = 1'b1;
    e.s = 16'h000F;
    e.c = 1'b1;
    e.v = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_bubble", 32'(busy), 1);
    chk("b2b_done_once", 32'(done), 0);
    wait_done("b2b_second");

    // Reset mid-RUN: outputs clear at once, no done for the aborted op
    issue(16'h1111, 16'h2222, 1'b0, 16'h0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    d0 = dones;
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_sum", 32'(sum), 0);
    chk("mid_rst_carry", 32'(carry), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(8);
    chk("mid_rst_no_done", 32'(dones - d0), 0);
    issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
    wait_done("after_rst");
    idle_cycles(3);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
